// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, iteration count and the two's-complement negate helper.
package muldiv_pkg;

    localparam int XLEN     = 32;
    localparam int ITER_CNT = 32;
    localparam int CNT_W    = $clog2(ITER_CNT);
    localparam int NEG_W    = 2 * XLEN;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Narrower values are zero-extended by the caller and truncated afterwards;
    // the low bits of the negation are unaffected by the extension.
    function automatic logic [NEG_W-1:0] negate(input logic [NEG_W-1:0] x);
        return (~x) + {{(NEG_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide),
// 33-cycle fixed latency. Signed MULT/DIV support is enabled by MULDIV_SIGNED_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;     // product, or dividend shifting into quotient
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] opd_q, opd_d;     // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dvz_q, dvz_d;

    always_comb begin
        a_neg    = op[1] & a[WIDTH-1];
        b_neg    = op[1] & b[WIDTH-1];
        a_mag    = a_neg ? WIDTH'(negate(NEG_W'(a))) : a;
        b_mag    = b_neg ? WIDTH'(negate(NEG_W'(b))) : b;
        prod_fix = neg_res_q ? W2'(negate(NEG_W'(acc_q))) : acc_q;
        // Divide by zero keeps an all-ones quotient regardless of signs.
        quo_fix  = dvz_q ? '1 :
                   (neg_res_q ? WIDTH'(negate(NEG_W'(acc_q[WIDTH-1:0]))) : acc_q[WIDTH-1:0]);
        rem_fix  = neg_rem_q ? WIDTH'(negate(NEG_W'(rem_q[WIDTH-1:0]))) : rem_q[WIDTH-1:0];
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1];

    always_comb begin
        a_mag    = a;
        b_mag    = b;
        prod_fix = acc_q;
        quo_fix  = acc_q[WIDTH-1:0];
        rem_fix  = rem_q[WIDTH-1:0];
    end
`endif

    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {2'b00, opd_q});
        div_diff  = div_shift[WIDTH:0] - {1'b0, opd_q};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dvz_d     = dvz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = op[0];
                    cnt_d    = CNT_W'(ITER_CNT - 1);
                    rem_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
                    opd_d    = op[0] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dvz_d     = (b == '0);
`endif
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_CALC: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    rem_d             = div_ge ? div_diff : div_shift[WIDTH:0];
                    acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            S_FIN: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dvz_q     <= dvz_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors with hand-computed HI/LO,
// expectations selected for the signed (MULDIV_SIGNED_EN) or unsigned build.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h, expected no done", hi, lo);
            end else begin
                e_mon = exp_q.pop_front();
                $display("result %0d: hi=0x%08h lo=0x%08h (expected 0x%08h 0x%08h)",
                         n_done, hi, lo, e_mon.hi, e_mon.lo);
                check("result_hi", hi, e_mon.hi);
                check("result_lo", lo, e_mon.lo);
                check("busy_at_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Issue one op at a negedge and count busy cycles until it drops.
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int n = 0;
        wait_idle();
        op = o; a = av; b = bv; start = 1'b1;
        exp_q.push_back('{hi: ehi, lo: elo});
        $display("issue op=%0d a=0x%08h b=0x%08h", o, av, bv);
        @(negedge clk);
        start = 1'b0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 32'd33);
    endtask

    // Signed/unsigned expectation pick.
    task automatic vec(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] shi, input logic [31:0] slo,
                       input logic [31:0] uhi, input logic [31:0] ulo);
`ifdef MULDIV_SIGNED_EN
        issue(o, av, bv, shi, slo);
`else
        issue(o, av, bv, uhi, ulo);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_lo, old_hi;
        int n;

        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // op, a, b, signed hi/lo, unsigned hi/lo; issued back-to-back
        vec(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 32'h00000001);
        vec(2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000004, 32'hFFFFFFF1);
        vec(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'h7FFFFFFC);
        vec(2'b01, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 32'h00000064, 32'hFFFFFFFF);
        vec(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000);
        vec(2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF);
        vec(2'b10, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 32'h00000006, 32'hFFFFFFF2);
        vec(2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32'h00000007, 32'h00000000);
        vec(2'b10, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 32'hFFFFFFF8, 32'h0000000F);
        vec(2'b00, 32'd0,        32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
        vec(2'b00, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 32'h00000001, 32'h23456780);

        // MTHI alone, then MTHI+MTLO together
        old_lo = lo;
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        $display("move mthi wdata=0x00001234 -> hi=0x%08h lo=0x%08h", hi, lo);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo_kept", lo, old_lo);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD0001;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        $display("move mthi+mtlo wdata=0xabcd0001 -> hi=0x%08h lo=0x%08h", hi, lo);
        check("mtboth_hi", hi, 32'hABCD0001);
        check("mtboth_lo", lo, 32'hABCD0001);

        // start with mtlo in IDLE, then start/mthi/mtlo while busy: all moves dropped
        old_hi = hi; old_lo = lo;
        op = 2'b01; a = 32'd1000; b = 32'd7; start = 1'b1; mtlo = 1'b1; wdata = 32'h55;
        exp_q.push_back('{hi: 32'd6, lo: 32'h8E});
        $display("issue op=1 a=0x000003e8 b=0x00000007 with mtlo wdata=0x00000055");
        @(negedge clk);
        start = 1'b0;
        check("start_wins_lo", lo, old_lo);
        check("start_wins_hi", hi, old_hi);
        n = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1; mthi = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0; mthi = 1'b0;
        check("busy_hold_hi", hi, old_hi);
        check("busy_hold_lo", lo, old_lo);
        while (busy && n < 100) begin
            @(negedge clk);
            if (busy) n++;
        end
        mtlo = 1'b0;
        check("busy_cycles_ignore", n, 32'd33);
        @(negedge clk);
        check("no_relaunch_busy", {31'b0, busy}, 32'd0);
        check("lo_not_moved", lo, 32'h8E);

        // Reset after 10 iterations of DIVU 9/3 aborts with no done
        op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1;
        $display("issue op=1 a=0x00000009 b=0x00000003 then reset");
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("after_abort_busy", {31'b0, busy}, 32'd0);
        check("after_abort_lo", lo, 32'd0);

        // Unit still works after the abort
        vec(2'b01, 32'd1000, 32'd7, 32'd6, 32'h8E, 32'd6, 32'h8E);

        @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        check("done_count", n_done, 32'd13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the EX stage. Consumes the two register-file read operands (rs, rt) and produces the HI/LO special registers for MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO. Results take 33 cycles of fixed latency. A `busy` output lets the hazard logic stall the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand and result width; HI and LO are each `WIDTH` bits.
- `clk` in 1: rising-edge clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: launch an operation; sampled only in IDLE.
- `op` in 2: operation select. 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `a` in WIDTH: rs operand (multiplicand / dividend).
- `b` in WIDTH: rt operand (multiplier / divisor).
- `mthi` in 1: write `wdata` to HI.
- `mtlo` in 1: write `wdata` to LO.
- `wdata` in WIDTH: MTHI/MTLO data (rs value).
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: one-cycle pulse when HI/LO hold a new result.
- `hi` out WIDTH: HI register (product upper half / remainder).
- `lo` out WIDTH: LO register (product lower half / quotient).

## Operation
- **States:**
  - IDLE: accepts `start` and `mthi`/`mtlo`.
  - CALC: 32 iterations, 5-bit counter from 31 down to 0.
  - FIN: sign fixup, HI/LO write.
- **IDLE & start:**
  - Latch operand magnitudes (absolute values only when signed and `MULDIV_SIGNED_EN`).
  - Latch the op and the result-sign flags.
  - Go to CALC.
- **Multiply:** shift-add, one multiplier bit per cycle, into a 2×WIDTH accumulator.
- **Divide:** restoring, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- **CALC exit:** counter == 0 → FIN.
- **FIN:**
  - Apply sign fixup:
    - product negated if sign(a) ≠ sign(b);
    - quotient negated if sign(a) ≠ sign(b);
    - remainder takes sign of dividend.
  - Write HI/LO, assert `done`, go to IDLE.
- **Divide by zero:** `lo` = all ones, `hi` = `a` (unsigned and signed). No exception raised.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): `lo` = 0x80000000, `hi` = 0.
- **MTHI/MTLO:**
  - In IDLE, write at the next edge; both may assert together.
  - Ignored while `busy`.
- **`start` and `mthi`/`mtlo` together in IDLE:** `start` wins; the move is dropped.
- **`start` while `busy`:** ignored. No queueing.
- **Reset:**
  - State IDLE, counter 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
  - Reset mid-operation aborts with no `done` and no HI/LO update.

## Timing
- `start` sampled at edge E0; `busy` is high from after E0 through E33 (33 cycles).
- Iterations occur at E1–E32; FIN occupies E32–E33.
- At E33, `hi`/`lo` update, `done` goes high for exactly one cycle, and `busy` falls.
- A new `start` may be sampled at E33's following edge (E34). Back-to-back issue gives a 34-cycle period.
- MTHI/MTLO: value visible on `hi`/`lo` one cycle after the sampling edge.
- `hi`/`lo` are stable at all times except on the FIN or move edge. The MFHI/MFLO path reads them directly.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - `op[1]` = 1 selects signed MULT/DIV.
  - Operands are converted to magnitude on start; sign fixup is applied in FIN.
- `MULDIV_SIGNED_EN` undefined:
  - `op[1]` ignored; all operations unsigned. `op[0]` selects multiply/divide.
  - No negation logic is synthesised; signed-overflow rule not applicable.

## Structure
- **Shared package `muldiv_pkg`:**
  - op encodings (OP_MULTU, OP_DIVU, OP_MULT, OP_DIV);
  - state enum (S_IDLE, S_CALC, S_FIN);
  - ITER_CNT = 32.
- **Sub-modules:** none required; a single module holds the FSM and datapath. The negate helper is a function in `muldiv_pkg`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 busy cycles, `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulses once.
- MULT a=0xFFFFFFFD (−3), b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Unsigned build: `hi`=0x00000004, `lo`=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=100, b=0 → `lo`=0xFFFFFFFF, `hi`=0x00000064.
- MTHI `wdata`=0x1234 in IDLE → `hi`=0x1234 next cycle. During `busy`, `start` and `mtlo` (`wdata`=0x55) are both ignored: result unchanged, `lo` ≠ 0x55.
- Start DIVU 9/3, then assert `rst` after iteration 10 → `busy`=0, `hi`=`lo`=0 immediately, and `done` never asserts.
